// File: rtl/burst_ram_arbiter_pkg.sv
// Shared encodings for the two-port BurstRAM arbiter.
// States, command codes and port indices used by the top and its slots.
package burst_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/burst_ram_arbiter_slot.sv
// One pending command register per cache port.
// Busy covers both a queued command and ownership of the RAM.
module burst_ram_arbiter_slot
    import burst_ram_arbiter_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_i,
    input  logic                      cmd_en_i,
    input  logic [DEPTH_BITWIDTH-1:0] addr_i,
    input  logic                      clear_i,
    input  logic                      own_i,
    output logic                      valid_o,
    output logic                      cmd_o,
    output logic [DEPTH_BITWIDTH-1:0] addr_o,
    output logic                      busy_o
);

    logic                      valid_q, valid_d;
    logic                      cmd_q, cmd_d;
    logic [DEPTH_BITWIDTH-1:0] addr_q, addr_d;
    logic                      load;

    assign busy_o  = valid_q | own_i;
    assign load    = cmd_en_i & ~busy_o;
    assign valid_o = valid_q;
    assign cmd_o   = cmd_q;
    assign addr_o  = addr_q;

    always_comb begin
        valid_d = valid_q;
        cmd_d   = cmd_q;
        addr_d  = addr_q;
        if (clear_i) valid_d = 1'b0;
        if (load) begin
            valid_d = 1'b1;
            cmd_d   = cmd_i;
            addr_d  = addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            cmd_q   <= CMD_READ;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            cmd_q   <= cmd_d;
            addr_q  <= addr_d;
        end
    end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Round-robin arbiter sharing one BurstRAM between the I-cache (port 0)
// and D-cache (port 1); one burst in flight at a time.
module burst_ram_arbiter
    import burst_ram_arbiter_pkg::*;
#(
    parameter int DEPTH_BITWIDTH = 4,
    parameter int DATA_BITWIDTH  = 64,
    parameter int BURST_COUNT    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       p0_cmd,
    input  logic                       p0_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]  p0_addr,
    input  logic [DATA_BITWIDTH-1:0]   p0_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0] p0_data_mask,
    output logic [DATA_BITWIDTH-1:0]   p0_rd_data,
    output logic                       p0_rd_data_valid,
    output logic                       p0_grant,
    output logic                       p0_busy,
    input  logic                       p1_cmd,
    input  logic                       p1_cmd_en,
    input  logic [DEPTH_BITWIDTH-1:0]  p1_addr,
    input  logic [DATA_BITWIDTH-1:0]   p1_wr_data,
    input  logic [DATA_BITWIDTH/8-1:0] p1_data_mask,
    output logic [DATA_BITWIDTH-1:0]   p1_rd_data,
    output logic                       p1_rd_data_valid,
    output logic                       p1_grant,
    output logic                       p1_busy,
    output logic                       br_cmd,
    output logic                       br_cmd_en,
    output logic [DEPTH_BITWIDTH-1:0]  br_addr,
    output logic [DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                       br_rd_data_valid,
    input  logic                       br_busy
);

    localparam int CW = $clog2(BURST_COUNT) + 1;
    localparam logic [CW-1:0] LAST = CW'(BURST_COUNT - 1);

    state_e                    state_q;
    logic                      owner_q, last_owner_q;
    logic [CW-1:0]             beat_q;

    logic [1:0]                slot_valid, slot_cmd, slot_busy, own;
    logic [DEPTH_BITWIDTH-1:0] slot_addr [2];
    logic                      own_cmd, next_owner, rd_phase, wr_phase;
    logic [DEPTH_BITWIDTH-1:0] own_addr;

    assign own[0] = (state_q != ST_IDLE) & (owner_q == PORT_I);
    assign own[1] = (state_q != ST_IDLE) & (owner_q == PORT_D);

    burst_ram_arbiter_slot #(.DEPTH_BITWIDTH(DEPTH_BITWIDTH)) u_slot0 (
        .clk(clk), .rst(rst), .cmd_i(p0_cmd), .cmd_en_i(p0_cmd_en),
        .addr_i(p0_addr), .clear_i(own[0] & (state_q == ST_ISSUE)),
        .own_i(own[0]), .valid_o(slot_valid[0]), .cmd_o(slot_cmd[0]),
        .addr_o(slot_addr[0]), .busy_o(slot_busy[0])
    );

    burst_ram_arbiter_slot #(.DEPTH_BITWIDTH(DEPTH_BITWIDTH)) u_slot1 (
        .clk(clk), .rst(rst), .cmd_i(p1_cmd), .cmd_en_i(p1_cmd_en),
        .addr_i(p1_addr), .clear_i(own[1] & (state_q == ST_ISSUE)),
        .own_i(own[1]), .valid_o(slot_valid[1]), .cmd_o(slot_cmd[1]),
        .addr_o(slot_addr[1]), .busy_o(slot_busy[1])
    );

    assign own_cmd    = slot_cmd[owner_q];
    assign own_addr   = slot_addr[owner_q];
    assign next_owner = (&slot_valid) ? ~last_owner_q : slot_valid[1];
    assign rd_phase   = (state_q == ST_ISSUE) | (state_q == ST_READ);
    assign wr_phase   = ((state_q == ST_ISSUE) & (own_cmd == CMD_WRITE))
                      | (state_q == ST_WRITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= PORT_I;
            last_owner_q <= PORT_D;
            beat_q       <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if ((|slot_valid) && !br_busy) begin
                        owner_q <= next_owner;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    last_owner_q <= owner_q;
                    if (own_cmd == CMD_WRITE) begin
                        if (BURST_COUNT > 1) begin
                            state_q <= ST_WRITE;
                            beat_q  <= CW'(1);
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (br_rd_data_valid && beat_q == LAST) begin
                        state_q <= ST_IDLE;
                        beat_q  <= '0;
                    end else begin
                        state_q <= ST_READ;
                        if (br_rd_data_valid) beat_q <= beat_q + CW'(1);
                    end
                end
                ST_READ: begin
                    if (br_rd_data_valid) begin
                        if (beat_q == LAST) begin
                            state_q <= ST_IDLE;
                            beat_q  <= '0;
                        end else begin
                            beat_q <= beat_q + CW'(1);
                        end
                    end
                end
                ST_WRITE: begin
                    if (beat_q == LAST) begin
                        state_q <= ST_IDLE;
                        beat_q  <= '0;
                    end else begin
                        beat_q <= beat_q + CW'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Write beats come straight from the owner so beat k lands in its k-th grant cycle.
    assign br_cmd_en    = (state_q == ST_ISSUE);
    assign br_cmd       = br_cmd_en ? own_cmd : CMD_READ;
    assign br_addr      = br_cmd_en ? own_addr : '0;
    assign br_wr_data   = !wr_phase ? '0
                        : (owner_q == PORT_D) ? p1_wr_data : p0_wr_data;
    assign br_data_mask = !wr_phase ? '0
                        : (owner_q == PORT_D) ? p1_data_mask : p0_data_mask;

    assign p0_rd_data       = br_rd_data;
    assign p1_rd_data       = br_rd_data;
    assign p0_rd_data_valid = br_rd_data_valid & rd_phase & (owner_q == PORT_I);
    assign p1_rd_data_valid = br_rd_data_valid & rd_phase & (owner_q == PORT_D);
    assign p0_grant         = own[0];
    assign p1_grant         = own[1];
    assign p0_busy          = slot_busy[0];
    assign p1_busy          = slot_busy[1];

endmodule

// File: tb/tb_burst_ram_arbiter.sv
// Directed bench for burst_ram_arbiter with a small BurstRAM model
// (masked writes, 2-cycle read latency, 2-cycle busy tail after bursts).
module tb_burst_ram_arbiter;

    localparam int AW = 4;
    localparam int DW = 64;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          p0_cmd, p0_cmd_en, p1_cmd, p1_cmd_en;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wr_data, p1_wr_data, p0_rd_data, p1_rd_data;
    logic [MW-1:0] p0_data_mask, p1_data_mask;
    logic          p0_rd_data_valid, p1_rd_data_valid;
    logic          p0_grant, p1_grant, p0_busy, p1_busy;
    logic          br_cmd, br_cmd_en;
    logic [AW-1:0] br_addr;
    logic [DW-1:0] br_wr_data;
    logic [MW-1:0] br_data_mask;
    logic [DW-1:0] br_rd_data = '0;
    logic          br_rd_data_valid = 1'b0;
    logic          br_busy;

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] W [4];

    burst_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_cmd(p0_cmd), .p0_cmd_en(p0_cmd_en), .p0_addr(p0_addr),
        .p0_wr_data(p0_wr_data), .p0_data_mask(p0_data_mask),
        .p0_rd_data(p0_rd_data), .p0_rd_data_valid(p0_rd_data_valid),
        .p0_grant(p0_grant), .p0_busy(p0_busy),
        .p1_cmd(p1_cmd), .p1_cmd_en(p1_cmd_en), .p1_addr(p1_addr),
        .p1_wr_data(p1_wr_data), .p1_data_mask(p1_data_mask),
        .p1_rd_data(p1_rd_data), .p1_rd_data_valid(p1_rd_data_valid),
        .p1_grant(p1_grant), .p1_busy(p1_busy),
        .br_cmd(br_cmd), .br_cmd_en(br_cmd_en), .br_addr(br_addr),
        .br_wr_data(br_wr_data), .br_data_mask(br_data_mask),
        .br_rd_data(br_rd_data), .br_rd_data_valid(br_rd_data_valid),
        .br_busy(br_busy)
    );

    // BurstRAM model
    logic [DW-1:0] mem [16] = '{default: '0};
    int            mmode = 0;
    int            mcnt = 0, mdly = 0, mtcnt = 0;
    logic [AW-1:0] maddr = '0;

    assign br_busy = (mmode != 0);

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                            input logic [DW-1:0] d,
                                            input logic [MW-1:0] m);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++)
            if (m[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mmode <= 0;
            br_rd_data_valid <= 1'b0;
        end else begin
            br_rd_data_valid <= 1'b0;
            case (mmode)
                0: if (br_cmd_en) begin
                    maddr <= br_addr;
                    mcnt  <= 1;
                    if (br_cmd) begin
                        mem[br_addr] <= merge(mem[br_addr], br_wr_data, br_data_mask);
                        mmode <= 1;
                    end else begin
                        mmode <= 2;
                        mcnt  <= 0;
                        mdly  <= 1;
                    end
                end
                1: begin
                    mem[maddr + AW'(mcnt)] <= merge(mem[maddr + AW'(mcnt)], br_wr_data, br_data_mask);
                    if (mcnt == 3) begin mmode <= 3; mtcnt <= 1; end
                    else mcnt <= mcnt + 1;
                end
                2: begin
                    if (mdly != 0) mdly <= mdly - 1;
                    else begin
                        br_rd_data_valid <= 1'b1;
                        br_rd_data <= mem[maddr + AW'(mcnt)];
                        if (mcnt == 3) begin mmode <= 3; mtcnt <= 1; end
                        else mcnt <= mcnt + 1;
                    end
                end
                default: begin
                    if (mtcnt == 0) mmode <= 0;
                    else mtcnt <= mtcnt - 1;
                end
            endcase
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (!p0_busy && !p1_busy && !br_busy) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        total++;
        if ({br_cmd_en, p0_grant, p1_grant, p0_busy, p1_busy,
             p0_rd_data_valid, p1_rd_data_valid} !== 7'b0) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 0", {br_cmd_en, p0_grant, p1_grant,
                     p0_busy, p1_busy, p0_rd_data_valid, p1_rd_data_valid});
        end
        total++;
        if (br_wr_data !== '0 || br_data_mask !== '0) begin
            bad++;
            $display("FAIL reset_wr: got %h/%h want 0/0", br_wr_data, br_data_mask);
        end
    endtask

    task automatic test_write();
        p1_cmd = 1'b1; p1_addr = 4'd2; p1_cmd_en = 1'b1;
        p1_data_mask = 8'hFF; p1_wr_data = '0;
        cyc();
        p1_cmd_en = 1'b0;
        #1;
        total++;
        if (p1_busy !== 1'b1 || br_cmd_en !== 1'b0) begin
            bad++;
            $display("FAIL wr_t1: busy=%b en=%b want 1 0", p1_busy, br_cmd_en);
        end
        cyc();
        p1_wr_data = W[0];
        #1;
        total++;
        if ({br_cmd_en, br_cmd, br_addr, p1_grant} !== {1'b1, 1'b1, 4'd2, 1'b1}) begin
            bad++;
            $display("FAIL wr_issue: got %b want 1_1_0010_1", {br_cmd_en, br_cmd, br_addr, p1_grant});
        end
        total++;
        if (br_wr_data !== W[0] || br_data_mask !== 8'hFF) begin
            bad++;
            $display("FAIL wr_beat0: got %h/%h want %h/ff", br_wr_data, br_data_mask, W[0]);
        end
        for (int k = 1; k < 4; k++) begin
            cyc();
            p1_wr_data = W[k];
            #1;
            total++;
            if (br_wr_data !== W[k] || br_data_mask !== 8'hFF || br_cmd_en !== 1'b0
                || p1_busy !== 1'b1) begin
                bad++;
                $display("FAIL wr_beat%0d: got %h/%h en=%b busy=%b want %h/ff 0 1",
                         k, br_wr_data, br_data_mask, br_cmd_en, p1_busy, W[k]);
            end
        end
        cyc();
        p1_wr_data = '0;
        #1;
        total++;
        if ({p1_busy, p1_grant} !== 2'b00 || br_wr_data !== '0) begin
            bad++;
            $display("FAIL wr_done: busy=%b grant=%b wd=%h want 0 0 0", p1_busy, p1_grant, br_wr_data);
        end
    endtask

    task automatic test_read();
        bit ok;
        int n;
        wait_idle(20, ok);
        p0_cmd = 1'b0; p0_addr = 4'd2; p0_cmd_en = 1'b1;
        cyc();
        p0_cmd_en = 1'b0;
        cyc();
        #1;
        total++;
        if ({br_cmd_en, br_cmd, br_addr, p0_grant} !== {1'b1, 1'b0, 4'd2, 1'b1}) begin
            bad++;
            $display("FAIL rd_issue: got %b want 1_0_0010_1", {br_cmd_en, br_cmd, br_addr, p0_grant});
        end
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (p0_rd_data_valid) begin
                total++;
                if (p0_rd_data !== W[n]) begin
                    bad++;
                    $display("FAIL rd_beat%0d: got %h want %h", n, p0_rd_data, W[n]);
                end
                n++;
            end
            total++;
            if (p1_rd_data_valid !== 1'b0) begin
                bad++;
                $display("FAIL rd_p1_valid: got %b want 0", p1_rd_data_valid);
            end
            if (n == 4) break;
            cyc();
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL rd_count: got %0d want 4", n);
        end
        cyc();
        total++;
        if ({p0_busy, p0_grant} !== 2'b00) begin
            bad++;
            $display("FAIL rd_done: got %b want 00", {p0_busy, p0_grant});
        end
    endtask

    task automatic test_tie();
        bit ok, seen;
        int n0, n1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        p0_cmd = 1'b0; p0_addr = 4'd0; p0_cmd_en = 1'b1;
        p1_cmd = 1'b0; p1_addr = 4'd4; p1_cmd_en = 1'b1;
        cyc();
        p0_cmd_en = 1'b0; p1_cmd_en = 1'b0;
        cyc();
        #1;
        total++;
        if ({br_cmd_en, br_addr, p0_grant, p1_grant, p1_busy} !==
            {1'b1, 4'd0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL tie_first: got %b want 1_0000_1_0_1",
                     {br_cmd_en, br_addr, p0_grant, p1_grant, p1_busy});
        end
        seen = 1'b0; n0 = 0; n1 = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (p0_rd_data_valid) n0++;
            if (p1_rd_data_valid) n1++;
            if (br_cmd_en) begin
                seen = 1'b1;
                total++;
                if (br_addr !== 4'd4 || p1_grant !== 1'b1 || n0 != 4 || br_busy !== 1'b0) begin
                    bad++;
                    $display("FAIL tie_second: addr=%0d grant1=%b p0beats=%0d brbusy=%b want 4 1 4 0",
                             br_addr, p1_grant, n0, br_busy);
                end
            end
            if (n1 == 4) break;
        end
        total++;
        if (!seen || n1 != 4) begin
            bad++;
            $display("FAIL tie_p1_done: seen=%b beats=%0d want 1 4", seen, n1);
        end
        wait_idle(20, ok);
        p0_addr = 4'd8; p0_cmd_en = 1'b1;
        cyc();
        p0_cmd_en = 1'b0;
        wait_idle(40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tie_solo_timeout: busy=%b want 0", p0_busy);
        end
        p0_addr = 4'd8;  p0_cmd_en = 1'b1;
        p1_addr = 4'd12; p1_cmd_en = 1'b1;
        cyc();
        p0_cmd_en = 1'b0; p1_cmd_en = 1'b0;
        cyc();
        #1;
        total++;
        if ({br_cmd_en, br_addr, p1_grant, p0_grant} !== {1'b1, 4'd12, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL tie2_first: got %b want 1_1100_1_0",
                     {br_cmd_en, br_addr, p1_grant, p0_grant});
        end
        wait_idle(60, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL tie2_timeout: busy=%b%b want 00", p0_busy, p1_busy);
        end
    endtask

    task automatic test_overlap();
        bit ok, seen;
        int n0, n1;
        wait_idle(20, ok);
        p1_cmd = 1'b0; p1_addr = 4'd2; p1_cmd_en = 1'b1;
        cyc();
        p1_cmd_en = 1'b0;
        cyc();
        cyc();
        p0_cmd = 1'b0; p0_addr = 4'd3; p0_cmd_en = 1'b1;
        cyc();
        p0_cmd_en = 1'b0;
        #1;
        total++;
        if ({p0_busy, p0_grant, p1_grant} !== 3'b101) begin
            bad++;
            $display("FAIL ovl_capture: got %b want 101", {p0_busy, p0_grant, p1_grant});
        end
        seen = 1'b0; n0 = 0; n1 = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (p0_grant && p1_grant) begin
                total++;
                bad++;
                $display("FAIL ovl_both_grant: got 11 want not both");
            end
            if (p1_rd_data_valid) n1++;
            if (p0_rd_data_valid) begin
                if (n0 == 0) begin
                    total++;
                    if (p0_rd_data !== W[1]) begin
                        bad++;
                        $display("FAIL ovl_data: got %h want %h", p0_rd_data, W[1]);
                    end
                end
                n0++;
            end
            if (br_cmd_en) begin
                seen = 1'b1;
                total++;
                if (br_addr !== 4'd3 || n1 != 4 || p0_grant !== 1'b1) begin
                    bad++;
                    $display("FAIL ovl_issue: addr=%0d p1beats=%0d grant0=%b want 3 4 1",
                             br_addr, n1, p0_grant);
                end
            end
            if (n0 == 4) break;
        end
        total++;
        if (!seen || n0 != 4) begin
            bad++;
            $display("FAIL ovl_done: seen=%b beats=%0d want 1 4", seen, n0);
        end
    endtask

    task automatic test_rst_mid();
        bit ok, got;
        int n;
        wait_idle(20, ok);
        p0_cmd = 1'b0; p0_addr = 4'd2; p0_cmd_en = 1'b1;
        cyc();
        p0_cmd_en = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (p0_rd_data_valid) begin got = 1'b1; break; end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL rst_no_beat: got 0 want 1");
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        total++;
        if ({br_cmd_en, p0_grant, p1_grant, p0_busy, p1_busy, p0_rd_data_valid,
             p1_rd_data_valid} !== 7'b0 || br_wr_data !== '0 || br_addr !== '0) begin
            bad++;
            $display("FAIL rst_mid_outs: got %b/%h/%h want 0", {br_cmd_en, p0_grant, p1_grant,
                     p0_busy, p1_busy, p0_rd_data_valid, p1_rd_data_valid}, br_wr_data, br_addr);
        end
        p0_addr = 4'd2; p0_cmd_en = 1'b1;
        cyc();
        p0_cmd_en = 1'b0;
        cyc();
        #1;
        total++;
        if ({br_cmd_en, br_addr} !== {1'b1, 4'd2}) begin
            bad++;
            $display("FAIL rst_reissue: got %b want 1_0010", {br_cmd_en, br_addr});
        end
        n = 0;
        for (int i = 0; i < 20 && n < 4; i++) begin
            if (p0_rd_data_valid) begin
                total++;
                if (p0_rd_data !== W[n]) begin
                    bad++;
                    $display("FAIL rst_beat%0d: got %h want %h", n, p0_rd_data, W[n]);
                end
                n++;
            end
            if (n < 4) cyc();
        end
        total++;
        if (n != 4) begin
            bad++;
            $display("FAIL rst_count: got %0d want 4", n);
        end
    endtask

    task automatic test_ignored();
        bit ok;
        int cnt, n;
        logic [AW-1:0] a;
        wait_idle(20, ok);
        p0_cmd = 1'b0; p0_addr = 4'd4; p0_cmd_en = 1'b1;
        cyc();
        #1;
        total++;
        if (p0_busy !== 1'b1) begin
            bad++;
            $display("FAIL ign_busy: got %b want 1", p0_busy);
        end
        p0_addr = 4'd9;
        cyc();
        p0_cmd_en = 1'b0;
        #1;
        cnt = 0; n = 0; a = '0;
        for (int i = 0; i < 30; i++) begin
            if (br_cmd_en) begin cnt++; a = br_addr; end
            if (p0_rd_data_valid) n++;
            cyc();
        end
        total++;
        if (cnt != 1 || a !== 4'd4 || n != 4 || p0_busy !== 1'b0) begin
            bad++;
            $display("FAIL ign_once: issues=%0d addr=%0d beats=%0d busy=%b want 1 4 4 0",
                     cnt, a, n, p0_busy);
        end
    endtask

    initial begin
        W[0] = 64'h1111_1111_1111_1111;
        W[1] = 64'h2222_2222_2222_2222;
        W[2] = 64'h3333_3333_3333_3333;
        W[3] = 64'h4444_4444_4444_4444;
        rst = 1'b1;
        p0_cmd = 1'b0; p0_cmd_en = 1'b0; p0_addr = '0;
        p0_wr_data = 64'hDEAD_BEEF_0BAD_F00D; p0_data_mask = 8'h0F;
        p1_cmd = 1'b0; p1_cmd_en = 1'b0; p1_addr = '0;
        p1_wr_data = '0; p1_data_mask = '0;
        test_reset();
        test_write();
        test_read();
        test_tie();
        test_overlap();
        test_rst_mid();
        test_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
